// File: rtl/evt_aer_pkg.sv
// evt_aer_pkg: shared constants and helpers
// for the address-event encoder.
package evt_aer_pkg;

  localparam int POL_LSB = 0;
  localparam int CH_LSB  = 1;
  localparam int DROP_W  = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ts_lsb(input int ch_w);
    return 1 + ch_w;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// evt_fifo: synchronous packet FIFO with full,
// empty and occupancy count.
module evt_fifo
  import evt_aer_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic         phi1b_dig,
  input  logic         rstb,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge phi1b_dig or negedge rstb) begin
    if (!rstb) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/evt_aer_encoder.sv
// evt_aer_encoder: edge-detects event flags, timestamps them and
// round-robin arbitrates them into a packet FIFO.
module evt_aer_encoder
  import evt_aer_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int TS_W  = 12,
  parameter int DEPTH = 4,
  parameter int CH_W  = clog2(N_CH)
) (
  input  logic                   phi1b_dig,
  input  logic                   rstb,
  input  logic [N_CH-1:0]        eve,
  input  logic [N_CH-1:0]        polxevent,
  output logic [TS_W+CH_W:0]     pkt_data,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic                   ts_wrap,
  output logic                   ovf,
  output logic [DROP_W-1:0]      drop_cnt
);

  localparam int PKT_W    = TS_W + CH_W + 1;
  localparam int TS_LSB   = ts_lsb(CH_W);
  localparam int DROP_MAX = (1 << DROP_W) - 1;
  localparam int AW       = clog2(DEPTH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic [TS_W-1:0]   ts_cnt;
  logic [N_CH-1:0]   eve_q;
  logic [N_CH-1:0]   evt;
  logic [N_CH-1:0]   pend;
  logic [N_CH-1:0]   pol_r;
  logic [TS_W-1:0]   ts_r [N_CH];
  logic [N_CH-1:0]   gnt_oh;
  logic [N_CH-1:0]   drop_v;
  logic [CH_W-1:0]   last;
  logic [CH_W-1:0]   gnt_ch;
  logic [CH_W-1:0]   rr_idx;
  logic              gnt_vld;
  logic [PKT_W-1:0]  pkt_w;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [AW:0]       fifo_cnt;
  int                drop_sum;
  logic [DROP_W-1:0] drop_nxt;

  always_ff @(posedge phi1b_dig or negedge rstb) begin
    if (!rstb) begin
      ts_cnt  <= '0;
      ts_wrap <= 1'b0;
    end else begin
      ts_cnt  <= ts_cnt + 1'b1;
      ts_wrap <= &ts_cnt;
    end
  end

  // Search starts one past the last winner.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    rr_idx  = '0;
    for (int i = 0; i < N_CH; i++) begin
      rr_idx = CH_W'((int'(last) + 1 + i) % N_CH);
      if (!gnt_vld && pend[rr_idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = rr_idx;
      end
    end
    gnt_vld = gnt_vld & ~fifo_full;
  end

  always_comb begin
    evt    = eve & ~eve_q;
    gnt_oh = '0;
    if (gnt_vld) gnt_oh[gnt_ch] = 1'b1;
    drop_v = evt & pend & ~gnt_oh;
  end

  always_comb begin
    drop_sum = int'(drop_cnt) + $countones(drop_v);
    drop_nxt = (drop_sum > DROP_MAX) ? DROP_W'(DROP_MAX)
                                     : DROP_W'(drop_sum);
  end

  always_comb begin
    pkt_w                  = '0;
    pkt_w[POL_LSB]         = pol_r[gnt_ch];
    pkt_w[CH_LSB +: CH_W]  = gnt_ch;
    pkt_w[TS_LSB +: TS_W]  = ts_r[gnt_ch];
  end

  // A granted slot may be refilled by a new event in the same cycle.
  always_ff @(posedge phi1b_dig or negedge rstb) begin
    if (!rstb) begin
      eve_q <= '0;
      pend  <= '0;
      pol_r <= '0;
      last  <= LAST_CH;
      for (int c = 0; c < N_CH; c++) begin
        ts_r[c] <= '0;
      end
    end else begin
      eve_q <= eve;
      if (gnt_vld) last <= gnt_ch;
      for (int c = 0; c < N_CH; c++) begin
        if (evt[c] && !drop_v[c]) begin
          pend[c]  <= 1'b1;
          pol_r[c] <= polxevent[c];
          ts_r[c]  <= ts_cnt;
        end else if (gnt_oh[c]) begin
          pend[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge phi1b_dig or negedge rstb) begin
    if (!rstb) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      ovf      <= ovf | (|drop_v);
      drop_cnt <= drop_nxt;
    end
  end

  assign fifo_pop  = pkt_ready & ~fifo_empty;
  assign pkt_valid = (fifo_cnt != '0);

  evt_fifo #(
    .W     (PKT_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .phi1b_dig (phi1b_dig),
    .rstb      (rstb),
    .push      (gnt_vld),
    .wdata     (pkt_w),
    .pop       (fifo_pop),
    .rdata     (pkt_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_evt_aer_encoder.sv
// tb_evt_aer_encoder: directed table and sequence
// checks for the address-event encoder.
module tb_evt_aer_encoder;

  logic        clk  = 1'b0;
  logic        rstb = 1'b0;
  logic [7:0]  eve  = '0;
  logic [7:0]  pol  = '0;
  logic        ready = 1'b0;
  logic [15:0] pkt_data;
  logic        pkt_valid;
  logic        ts_wrap;
  logic        ovf;
  logic [7:0]  drop_cnt;

  logic [7:0]  eve4 = '0;
  logic [7:0]  pol4 = '0;
  logic        ready4 = 1'b1;
  logic [7:0]  pkt_data4;
  logic        pkt_valid4;
  logic        ts_wrap4;
  logic        ovf4;
  logic [7:0]  drop_cnt4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  evt_aer_encoder dut (
    .phi1b_dig (clk),
    .rstb      (rstb),
    .eve       (eve),
    .polxevent (pol),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (ready),
    .ts_wrap   (ts_wrap),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt)
  );

  evt_aer_encoder #(.TS_W(4)) dut4 (
    .phi1b_dig (clk),
    .rstb      (rstb),
    .eve       (eve4),
    .polxevent (pol4),
    .pkt_data  (pkt_data4),
    .pkt_valid (pkt_valid4),
    .pkt_ready (ready4),
    .ts_wrap   (ts_wrap4),
    .ovf       (ovf4),
    .drop_cnt  (drop_cnt4)
  );

  typedef struct {
    int          n;
    logic [7:0]  eve;
    logic [7:0]  pol;
    logic        ready;
    logic        exp_v;
    logic [15:0] exp_d;
    logic        exp_ovf;
  } row_t;

  row_t tbl [15];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    eve   = '0;
    pol   = '0;
    eve4  = '0;
    pol4  = '0;
    rstb  = 1'b0;
    #2;
    check("rst.valid", pkt_valid, 0);
    check("rst.data", pkt_data, 0);
    check("rst.wrap", ts_wrap, 0);
    check("rst.ovf", ovf, 0);
    check("rst.drop", drop_cnt, 0);
    check("rst.pend", dut.pend, 0);
    #1;
    rstb = 1'b1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        eve   = tbl[r].eve;
        pol   = tbl[r].pol;
        ready = tbl[r].ready;
        tick();
        check($sformatf("row%0d.valid", r), pkt_valid, tbl[r].exp_v);
        if (tbl[r].exp_v)
          check($sformatf("row%0d.data", r), pkt_data, tbl[r].exp_d);
        check($sformatf("row%0d.ovf", r), ovf, tbl[r].exp_ovf);
      end
    end
  endtask

  int          chs [6];
  logic [15:0] rec [8];
  int          got;
  logic [15:0] exp16;
  logic [7:0]  first4;

  initial begin
    // n, eve, pol, ready, exp_valid, exp_data, exp_ovf
    tbl[0]  = '{5,  8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{1,  8'h08, 8'h08, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[2]  = '{1,  8'h08, 8'h08, 1'b1, 1'b1, 16'h0057, 1'b0};
    tbl[3]  = '{1,  8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[4]  = '{3,  8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[5]  = '{20, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[6]  = '{1,  8'h23, 8'h21, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[7]  = '{1,  8'h23, 8'h21, 1'b1, 1'b1, 16'h0141, 1'b0};
    tbl[8]  = '{1,  8'h00, 8'h00, 1'b1, 1'b1, 16'h0142, 1'b0};
    tbl[9]  = '{1,  8'h00, 8'h00, 1'b1, 1'b1, 16'h014B, 1'b0};
    tbl[10] = '{1,  8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[11] = '{1,  8'h41, 8'h40, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[12] = '{1,  8'h41, 8'h40, 1'b1, 1'b1, 16'h019D, 1'b0};
    tbl[13] = '{1,  8'h00, 8'h00, 1'b1, 1'b1, 16'h0190, 1'b0};
    tbl[14] = '{1,  8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0};

    // single event held two cycles, then simultaneous events
    do_reset();
    run_rows(0, 4);
    do_reset();
    run_rows(5, 14);

    // timestamp wrap on the 4-bit instance
    do_reset();
    got    = 0;
    first4 = '0;
    for (int i = 0; i < 20; i++) begin
      eve4 = (i == 15 || i == 16) ? 8'h02 : 8'h00;
      pol4 = eve4;
      tick();
      check($sformatf("wrap%0d", i), ts_wrap4, (i + 1 == 16));
      if (pkt_valid4 && got == 0) begin
        got    = 1;
        first4 = pkt_data4;
      end
    end
    check("wrap.got", got, 1);
    check("wrap.pkt", first4, 8'hF3);

    // backpressure: six staggered events, FIFO holds four
    do_reset();
    ready = 1'b0;
    chs   = '{2, 3, 4, 5, 6, 7};
    for (int k = 0; k < 7; k++) begin
      eve = '0;
      if (k < 6) eve[chs[k]] = 1'b1;
      if (k > 0) eve[chs[k-1]] = 1'b1;
      pol = eve & 8'hAA;
      tick();
    end
    eve = '0;
    pol = '0;
    for (int k = 0; k < 3; k++) tick();
    check("bp.count", dut.fifo_cnt, 4);
    check("bp.pend", dut.pend, 8'hC0);
    check("bp.ovf", ovf, 0);
    check("bp.valid", pkt_valid, 1);
    check("bp.head", pkt_data, 16'h0004);
    tick();
    check("bp.stable", pkt_data, 16'h0004);
    ready = 1'b1;
    got   = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      if (pkt_valid) begin
        rec[got] = pkt_data;
        got++;
      end
      tick();
    end
    check("bp.got", got, 6);
    for (int k = 0; k < 6 && k < got; k++) begin
      exp16 = {12'(k), 3'(chs[k]), 1'(chs[k] % 2)};
      check($sformatf("bp.pkt%0d", k), rec[k], exp16);
    end

    // overflow: FIFO full, second channel-2 event is dropped
    do_reset();
    ready = 1'b0;
    eve   = 8'h1B;
    pol   = 8'h00;
    tick();
    tick();
    eve = '0;
    for (int k = 0; k < 3; k++) tick();
    eve = 8'h04;
    pol = 8'h00;
    tick();
    tick();
    eve = '0;
    tick();
    check("ov.pre_ovf", ovf, 0);
    check("ov.pend2", dut.pend[2], 1);
    eve = 8'h04;
    pol = 8'h04;
    tick();
    tick();
    eve = '0;
    pol = '0;
    check("ov.ovf", ovf, 1);
    check("ov.drop", drop_cnt, 1);
    ready = 1'b1;
    got   = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (pkt_valid) begin
        rec[got] = pkt_data;
        got++;
      end
      tick();
    end
    check("ov.got", got, 5);
    check("ov.pkt0", rec[0], 16'h0000);
    check("ov.pkt3", rec[3], 16'h0008);
    check("ov.pkt_ch2", rec[4], 16'h0054);
    check("ov.sticky", ovf, 1);

    // reset mid-operation with queued and pending events
    ready = 1'b0;
    eve   = 8'h1F;
    tick();
    tick();
    eve = '0;
    tick();
    tick();
    check("mr.count", dut.fifo_cnt, 3);
    check("mr.npend", $countones(dut.pend), 2);
    check("mr.ovf_pre", ovf, 1);
    rstb = 1'b0;
    #1;
    check("mr.valid", pkt_valid, 0);
    check("mr.ovf", ovf, 0);
    check("mr.drop", drop_cnt, 0);
    check("mr.pend", dut.pend, 0);
    #1;
    rstb = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    eve   = 8'h40;
    pol   = 8'h40;
    ready = 1'b1;
    tick();
    check("mr.lat1", pkt_valid, 0);
    tick();
    eve = '0;
    pol = '0;
    check("mr.valid2", pkt_valid, 1);
    check("mr.pkt", pkt_data, 16'h003D);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/evt_aer_encoder.md
# evt_aer_encoder

Multi-channel address-event encoder placed directly downstream of the per-channel `dig_evegen` event generators. Edge-detects each channel's `eve` and captures its polarity from `polxevent` together with a free-running timestamp. Arbitrates pending channels round-robin into a small packet FIFO, which drains over a valid/ready handshake to the readout logic. Everything runs on `phi1b_dig`, the same clock as the event generators, so no synchroniser is needed on `eve`/`polxevent`.

## Interface
- `N_CH`, default 8: number of event-generator channels (≥2).
- `TS_W`, default 12: timestamp width.
- `DEPTH`, default 4: packet FIFO depth (power of 2).
- `CH_W`, derived as clog2(`N_CH`): channel address width.
- `phi1b_dig`, in, 1: the block's single clock. All state updates on its rising edge.
- `rstb`, in, 1: reset, asynchronous and active-low.
- `eve`, in, `N_CH`: per-channel event flags from `dig_evegen`.
- `polxevent`, in, `N_CH`: per-channel polarity.
  - 1 = up crossing.
  - Meaningful only while `eve` is 1.
- `pkt_data`, out, `TS_W+CH_W+1`: packet, laid out as {ts, ch, pol} with pol at the LSB.
- `pkt_valid`, out, 1: FIFO non-empty.
- `pkt_ready`, in, 1: consumer accepts the packet.
- `ts_wrap`, out, 1: one-cycle pulse when the timestamp wraps.
- `ovf`, out, 1: sticky event-lost flag. Cleared only by reset.
- `drop_cnt`, out, 8: count of lost events. Saturates at 255.

## Operation
- **Timestamp:** `ts_cnt` increments every cycle.
  - Wraps from 2^TS_W−1 to 0.
  - `ts_wrap` is 1 in the cycle where `ts_cnt` = 0 following a wrap. It is not asserted for the first cycle after reset.
- **Event detect:** each channel registers `eve_q`.
  - An event on channel c is `eve[c]` & !`eve_q[c]`.
  - `dig_evegen` holds `eve` high for two cycles per transition; this detection yields exactly one event per transition.
- **Capture:** on an event, set `pend[c]`=1, `pol_r[c]`=`polxevent[c]` and `ts_r[c]`=`ts_cnt`.
  - If `pend[c]` is already 1 and is not being granted this cycle, the new event is dropped.
  - A dropped event leaves the stored data unchanged, sets `ovf`=1 and increments `drop_cnt`.
  - If `pend[c]` is granted in the same cycle as a new event, the new event is captured (slot reuse) and nothing is dropped.
- **Arbiter:** round-robin over `pend`.
  - The search starts at `last`+1, modulo `N_CH`.
  - `last` resets to `N_CH`−1, so channel 0 wins first.
  - At most one grant per cycle, and only when the FIFO is not full at the start of the cycle.
  - A grant writes {`ts_r`, c, `pol_r`} to the FIFO, clears `pend[c]` and sets `last`=c.
  - A pending channel is never lost to FIFO backpressure; it waits.
- **FIFO:**
  - A pop occurs when `pkt_valid` & `pkt_ready`.
  - A write while full is never attempted, even if a pop is happening in the same cycle.
  - Simultaneous push and pop while not full leaves the count unchanged.
  - `pkt_data` shows the head entry. It is stable while `pkt_valid` & !`pkt_ready`.
- **Reset values:**
  - All outputs 0 (`pkt_valid`, `pkt_data`, `ts_wrap`, `ovf`, `drop_cnt`).
  - Internal state: `ts_cnt`=0, `pend`=0, `eve_q`=0, FIFO count 0.
  - Asserting reset mid-operation discards all pending and queued events immediately and asynchronously.

## Timing
- Call E the edge at which the event is detected. Relative to E:
  - The capture flops update at E.
  - The grant and FIFO write occur at E+1, provided the FIFO is not full and no other channel wins.
  - `pkt_valid` rises after E+1, assuming the FIFO was empty.
- Minimum latency from detection to `pkt_valid` is 2 edges.
- The packet timestamp equals `ts_cnt` at E, independent of queuing delay.
- Throughput is 1 packet per cycle sustained.
- k simultaneous events drain in k consecutive cycles, all carrying the same ts.

## Structure
- Package `evt_aer_pkg` holds:
  - the `clog2` function;
  - packet field offsets (`POL_LSB`=0, `CH_LSB`=1, `TS_LSB`=1+CH_W);
  - `DROP_W`=8.
- Sub-module `evt_fifo`: a parameterised synchronous FIFO with width, depth, full/empty and count.
  - Clocked by `phi1b_dig`, reset by `rstb`.
  - The top level contains the timestamp counter, edge detect, capture registers, arbiter and overflow logic.

## Test plan
- **Single event, held high:** `eve[3]` high for 2 cycles with `polxevent[3]`=1, detected at `ts_cnt`=5. Requires exactly one packet {ts=5, ch=3, pol=1}, `pkt_valid` 2 edges after detection, and no second packet.
- **Simultaneous events:** events on channels 0, 1 and 5 in the same cycle, detected at ts=20, with `pkt_ready`=1. Requires packets ch0, ch1, ch5 on consecutive cycles, all ts=20. Then a new event on channel 0 plus one on channel 6 must be granted 6 before 0.
- **Backpressure without loss:** `pkt_ready`=0 with six single events on distinct channels. Requires FIFO count 4, 2 channels still pending, `ovf`=0. After `pkt_ready`=1, requires all 6 packets delivered in round-robin order with their original timestamps.
- **Overflow:** FIFO full, with two events on channel 2 separated by 3 cycles, the first with pol=0 and the second with pol=1. Requires `ovf`=1, `drop_cnt`=1, and the eventual channel-2 packet carrying pol=0 and the first timestamp.
- **Timestamp wrap:** run with `TS_W`=4 for 20 cycles. Requires `ts_wrap` high for exactly one cycle when `ts_cnt` goes 15 to 0. An event detected at ts=15 must report ts=15.
- **Reset mid-operation:** with 3 queued packets and 2 pending channels, pulse `rstb` low between edges. Requires `pkt_valid`=0, `ovf`=0 and `drop_cnt`=0 asynchronously. After release, the first new event must carry a timestamp counted from 0.
